// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector.
// Matches a run-time pattern of 1..PAT_W bits on a qualified serial stream,
// in overlapping or non-overlapping mode. It produces a registered one-cycle
// match pulse and keeps a saturating match counter.
module seq_detect_prog #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'h0B),
    parameter int               RST_LEN = 4,
    parameter bit               RST_OVL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Live configuration
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;

    // Stream state: last PAT_W accepted bits (newest at [0]) and how many
    // accepted bits are valid in that window
    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] fill;

    logic             accept;
    logic [PAT_W-1:0] history_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] len_mask;
    logic             hit;
    logic [LEN_W-1:0] len_clamped;

    // A bit counts only when it is qualified and not shadowed by a config write
    assign accept       = in_valid && !cfg_we;
    assign history_next = {history[PAT_W-2:0], in};
    assign fill_next    = (fill == LEN_MAX) ? fill : fill + 1'b1;
    assign len_clamped  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    // Build a mask selecting the low len bits so pattern bits above len are ignored
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len));
        end
    end

    // Match test runs on the post-shift window so the pulse follows the final bit by one cycle
    always_comb begin
        hit = accept && (len != '0) && (fill_next >= len) &&
              (((history_next ^ pattern) & len_mask) == '0);
    end

    // Configuration, stream window and match pulse
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            pattern <= RST_PAT;
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVL;
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (cfg_we) begin
                pattern <= cfg_pattern;
                len     <= len_clamped;
                overlap <= cfg_overlap;
                history <= '0;
                fill    <= '0;
            end else if (accept) begin
                history <= history_next;
                // Non-overlap restarts the count so the next match needs len fresh bits
                fill    <= (hit && !overlap) ? '0 : fill_next;
            end
        end
    end

    // Saturating match counter; clear wins over a same-cycle match
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

    assign cnt_sat = (match_cnt == CNT_MAX);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: the accepted bits since the last restart, newest last
    bit       q[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_cnt;
    bit       m_match;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_update();
        bit hit;
        m_match = 1'b0;
        if (rst) begin
            q.delete();
            m_pat = 8'h0B;
            m_len = 4;
            m_ovl = 1'b1;
            m_cnt = 0;
            return;
        end
        if (cfg_we) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
            m_ovl = cfg_overlap;
            q.delete();
        end else if (in_valid) begin
            q.push_back(in);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (m_len != 0 && q.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
                if (hit) begin
                    m_match = 1'b1;
                    if (!m_ovl) q.delete();
                end
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (m_match && m_cnt < CMAX) m_cnt++;
    endtask

    // One clock: inputs already driven; update model at the edge, compare #1 later
    task automatic tick(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".match"}, match, m_match);
        check({tag, ".cnt"}, match_cnt, m_cnt);
        check({tag, ".sat"}, cnt_sat, (m_cnt == CMAX));
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; in = 0; cfg_we = 0; cnt_clr = 0;
    endtask

    task automatic send_bit(input string tag, input logic b);
        idle_inputs();
        in_valid = 1'b1;
        in = b;
        tick(tag);
    endtask

    task automatic send_bits(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(tag, bits[i]);
    endtask

    task automatic configure(input string tag, input logic [7:0] p, input int l, input logic o);
        idle_inputs();
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
        in_valid = 1'b1; in = 1'b1;
        tick(tag);
    endtask

    task automatic clear_cnt(input string tag);
        idle_inputs();
        cnt_clr = 1'b1;
        tick(tag);
    endtask

    initial begin
        idle_inputs();
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // Reset defaults
        rst = 1'b1;
        tick("reset");
        idle_inputs();
        tick("reset_idle");
        check("reset.match_low", match, 1'b0);

        // 1: default pattern 1011 overlap, stream 1011011
        send_bits("t1", 16'b1011011, 7);
        check("t1.cnt_final", match_cnt, 2);

        // 2: non-overlap, 1011 0111 011 -> matches after bits 4 and 11
        clear_cnt("t2_clr");
        configure("t2_cfg", 8'h0B, 4, 1'b0);
        send_bits("t2", 16'b10110111011, 11);
        check("t2.cnt_final", match_cnt, 2);

        // 3: valid gaps between bits, no pulses during gaps
        clear_cnt("t3_clr");
        configure("t3_cfg", 8'h0B, 4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            send_bit("t3", (4'b1011 >> i) & 1'b1);
            idle_inputs();
            tick("t3_gap");
        end
        check("t3.cnt_final", match_cnt, 1);

        // 4: all-ones pattern, ten ones overlap -> three back-to-back pulses
        clear_cnt("t4_clr");
        configure("t4_cfg", 8'hFF, 8, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send_bit("t4", 1'b1);
            if (i >= 7) check("t4.pulse", match, 1'b1);
        end
        check("t4.cnt_sat", cnt_sat, 1'b1);

        // 5: saturation with len 1, then clear colliding with a match
        clear_cnt("t5_clr");
        configure("t5_cfg", 8'h01, 1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send_bit("t5", 1'b1);
            check("t5.seq", match_cnt, (i < 3) ? i : 3);
            check("t5.sat", cnt_sat, (i >= 3));
        end
        idle_inputs();
        in_valid = 1'b1; in = 1'b1; cnt_clr = 1'b1;
        tick("t5_clrhit");
        check("t5.clr_cnt", match_cnt, 0);
        check("t5.clr_pulse", match, 1'b1);

        // 6: config write and reset both discard partial progress
        configure("t6_cfg0", 8'h0B, 4, 1'b1);
        send_bits("t6a", 16'b101, 3);
        configure("t6_cfg1", 8'h0B, 4, 1'b1);
        send_bit("t6a", 1'b1);
        check("t6.no_match_cfg", match, 1'b0);
        send_bits("t6b", 16'b1011, 4);
        check("t6.match_after_cfg", match, 1'b1);
        send_bits("t6c", 16'b101, 3);
        idle_inputs();
        rst = 1'b1;
        tick("t6_rst");
        send_bit("t6c", 1'b1);
        check("t6.no_match_rst", match, 1'b0);

        // Length clamp and len=0
        configure("clamp_cfg", 8'hFF, 15, 1'b1);
        send_bits("clamp", 16'hFFFF, 9);
        configure("len0_cfg", 8'h00, 0, 1'b1);
        send_bits("len0", 16'h0000, 9);

        // Randomized traffic, short patterns favoured so matches are frequent
        for (int n = 0; n < 4000; n++) begin
            idle_inputs();
            rst      = ($urandom_range(0, 299) == 0);
            cfg_we   = ($urandom_range(0, 59) == 0);
            cnt_clr  = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in       = $urandom_range(0, 1);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15))
                                                      : LEN_W'($urandom_range(1, 4));
            cfg_overlap = $urandom_range(0, 1);
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial bit-pattern detector, the parametrised successor to the fixed-pattern Moore sequence detectors in the fsm library. It matches a run-time pattern of 1..PAT_W bits on a qualified serial input stream, in overlap or non-overlap mode. It emits a registered one-cycle match pulse and keeps a saturating match counter. It sits between a serial front end (deserialiser or line decoder) and control logic that needs frame-sync or marker detection.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
RST_PAT, 8'h0B, pattern loaded at reset; lower PAT_W bits used
RST_LEN, 4, pattern length loaded at reset (1..PAT_W)
RST_OVL, 1, overlap mode loaded at reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  qualifies in; bit sampled only when high
in  input  1  serial data bit
cfg_we  input  1  one-cycle pulse: load cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  $clog2(PAT_W+1)  pattern length; 0 disables detection
cfg_overlap  input  1  1 = overlapping matches allowed
cnt_clr  input  1  clears match_cnt
match  output  1  registered one-cycle pulse per detected match
match_cnt  output  CNT_W  saturating count of matches
cnt_sat  output  1  high while match_cnt equals all-ones

Behaviour:
- Reset (rst high at a posedge): history=0, fill=0, match=0, match_cnt=0, cnt_sat=0, pattern=RST_PAT, len=RST_LEN, overlap=RST_OVL.
- Internal state:
  - history is a PAT_W shift register. On an accepted bit it shifts left and the new bit enters at [0].
  - fill counts accepted bits. It saturates at PAT_W.
- Accepted bit: in_valid=1 and cfg_we=0. When in_valid=0, history, fill and match state hold, and match is 0 the next cycle.
- Match condition is evaluated on the post-shift history: len!=0, and fill_next>=len, and history_next[len-1:0]==pattern[len-1:0].
- Latency: match goes high in the cycle after the clock edge that samples the final pattern bit. It lasts exactly one cycle, even if the next accepted bit completes a match again; consecutive matches produce consecutive pulses.
- Overlap mode: history and fill are kept after a match, so suffixes of a match can start the next one.
- Non-overlap mode: on a match, fill is set to 0, so the next match needs len fresh accepted bits.
- Configuration write (cfg_we=1):
  - Latches cfg_pattern, cfg_len and cfg_overlap, and clears history and fill.
  - Any in_valid bit in that cycle is discarded, and match=0 the next cycle.
  - cfg_len>PAT_W is clamped to PAT_W.
  - Pattern bits at or above len are ignored.
- len=0: match is never asserted; bits are still shifted.
- match_cnt:
  - Increments by 1 on each match.
  - Holds at 2^CNT_W-1; cnt_sat goes high there and stays high until cleared.
  - cnt_clr has priority over a same-cycle match: the result is 0 and that match is not counted, though the match pulse still occurs.
  - cfg_we does not clear match_cnt.
- rst mid-stream: partial progress is lost, and configuration reverts to the RST_* values.
- len=1: every accepted bit equal to pattern[0] gives a match, in either mode.

Test Plan:
1. Reset defaults (pattern 1011, len 4, overlap), stream 1,0,1,1,0,1,1 with in_valid=1 -> match pulses after bits 4 and 7; match_cnt=2.
2. cfg_we with pattern 8'h0B, len 4, overlap=0; stream 1,0,1,1,0,1,1,1,0,1,1 -> match after bits 4 and 11 only; match_cnt=2.
3. Stream 1,0,1,1 with in_valid toggled low between each bit -> a single match, 1 cycle after the 4th valid bit; no match pulses during gaps.
4. Pattern 8'hFF, len 8; stream ten 1s in overlap mode -> match after bits 8, 9 and 10, as three consecutive single-cycle pulses.
5. CNT_W=2, five matches -> match_cnt sequence 1,2,3,3,3 and cnt_sat high from the 3rd match. Then cnt_clr in the same cycle as a match -> match_cnt=0 and match still pulses.
6. Stream 1,0,1, then cfg_we (same pattern), then 1 -> no match; 1,0,1,1 after the cfg_we -> match. rst asserted after 1,0,1 -> no match on a following 1.
